// File: rtl/shift_out_sm.sv
// shift_out_sm
// Parallel-to-serial nibble transmitter. A WORD_W-bit word is captured through
// a load/ready handshake and sent out as WORD_W/NIB_W nibbles, most significant
// nibble first. One nibble leaves per clock while enable is high. A receiver
// that shifts nibbles into its LSB end therefore rebuilds the original word.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        synchronous active-high reset, overrides every other input
//   enable     advance permission; a nibble is consumed only when this is high
//   load       request to capture din; honoured only while ready is high
//   din        parallel word to transmit
//   ready      high while idle and able to accept a word
//   dout       nibble currently presented (zero outside the shifting phase)
//   dout_valid dout is emitted this cycle
//   last       accompanies the final nibble of a word
//   done       one-cycle pulse in the cycle after the final nibble
//   count      nibbles still to be emitted for the current word

module shift_out_sm #(
   parameter int WORD_W = 16,
   parameter int NIB_W = 4,
   localparam int NIBBLES = WORD_W / NIB_W,
   localparam int CNT_W = $clog2(NIBBLES) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              load,
   input  logic [WORD_W-1:0] din,
   output logic              ready,
   output logic [NIB_W-1:0]  dout,
   output logic              dout_valid,
   output logic              last,
   output logic              done,
   output logic [CNT_W-1:0]  count
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t            state;
   logic [WORD_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;

   // Main controller. The word sits in shreg with the next nibble at the top.
   // Each consumed nibble shifts the register left and zero-fills it, so shreg
   // is already all zeros when the controller reaches DONE. A held enable=0
   // freezes everything, so a nibble is neither lost nor repeated. The count
   // only decrements while it is nonzero in SHIFT, so it cannot wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  shreg <= din;
                  cnt   <= CNT_W'(NIBBLES);
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (enable) begin
                  shreg <= shreg << NIB_W;
                  cnt   <= cnt - 1'b1;
                  if (cnt == CNT_W'(1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Output decode. Everything except dout_valid and last comes straight from
   // registers. Those two also follow enable, because the link needs to know
   // in the same cycle whether the presented nibble is being taken.
   always_comb begin
      ready      = (state == IDLE);
      done       = (state == DONE);
      dout       = (state == SHIFT) ? shreg[WORD_W-1 -: NIB_W] : '0;
      dout_valid = (state == SHIFT) && enable;
      last       = dout_valid && (cnt == CNT_W'(1));
      count      = cnt;
   end

endmodule
